// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell/state types and helpers for the win scanner
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10,
    BAD   = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only X and O are player marks; EMPTY and BAD never win and count as empty.
  function automatic logic is_mark(input cell_t c);
    return (c == X) || (c == O);
  endfunction

endpackage

// File: rtl/win_scanner_line_same.sv
// rtl/win_scanner_line_same.sv - N-way equality check of one board line
module line_same
  import ttt_pkg::*;
#(
  parameter int N = 3
) (
  input  cell_t cells [N],
  output logic  y,
  output cell_t mark
);

  always_comb begin
    y = is_mark(cells[0]);
    for (int i = 1; i < N; i++) begin
      if (cells[i] != cells[0]) y = 1'b0;
    end
    mark = y ? cells[0] : EMPTY;
  end

endmodule

// File: rtl/win_scanner.sv
// rtl/win_scanner.sv - sequential N-in-a-row detector, one line per cycle
module win_scanner
  import ttt_pkg::*;
#(
  parameter int N = 3,
  localparam int LINES = 2 * N + 2,
  localparam int IDXW  = $clog2(LINES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*N*N-1:0]     board,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           winner,
  output logic [IDXW-1:0]      win_line,
  output logic                 draw
);

  state_t              r_state;
  state_t              w_next;
  logic [2*N*N-1:0]    r_snap;
  logic [IDXW-1:0]     r_idx;
  logic [1:0]          r_winner;
  logic [IDXW-1:0]     r_win_line;
  logic                r_draw;

  cell_t               w_grid [N][N];
  cell_t               w_cells [N];
  logic                w_line_win;
  cell_t               w_mark;
  logic                w_full;
  logic                w_last;

  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      assign w_grid[gr][gc] = cell_t'(r_snap[2*(gr*N+gc) +: 2]);
    end
  end

  // Gather the N cells of line r_idx: rows, then columns, then both diagonals.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_cells[i] = EMPTY;
      for (int k = 0; k < N; k++) begin
        if (r_idx == IDXW'(k))     w_cells[i] = w_grid[k][i];
        if (r_idx == IDXW'(N + k)) w_cells[i] = w_grid[i][k];
      end
      if (r_idx == IDXW'(2 * N))     w_cells[i] = w_grid[i][i];
      if (r_idx == IDXW'(2 * N + 1)) w_cells[i] = w_grid[i][N-1-i];
    end
  end

  line_same #(.N(N)) u_line_same (
    .cells (w_cells),
    .y     (w_line_win),
    .mark  (w_mark)
  );

  always_comb begin
    w_full = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!is_mark(w_grid[r][c])) w_full = 1'b0;
      end
    end
  end

  assign w_last = (r_idx == IDXW'(LINES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_snap     <= '0;
      r_idx      <= '0;
      r_winner   <= 2'b00;
      r_win_line <= '0;
      r_draw     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_snap     <= board;
            r_idx      <= '0;
            r_winner   <= 2'b00;
            r_win_line <= '0;
            r_draw     <= 1'b0;
          end
        end
        SCAN: begin
          if (w_line_win) begin
            r_winner   <= w_mark;
            r_win_line <= r_idx;
          end else if (w_last) begin
            r_draw <= w_full;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SCAN;
      SCAN:    if (w_line_win || w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == SCAN);
    done     = (r_state == DONE);
    winner   = r_winner;
    win_line = r_win_line;
    draw     = r_draw;
  end

endmodule
